hazard_fwd_scoreboard: RTL and testbench
========================================

Name: hazard_fwd_scoreboard

Overview:
Parametrised hazard and forwarding controller for the in-order 5-stage core (IF/ID/EX/MEM/WB). It replaces the separate load-use detector and the forwarding unit with one scoreboard that owns the EX/MEM/WB destination-tracking pipeline. It also generalises register-file size, data width, source-operand count, and R0 handling. Its outputs are the ID stall, the per-source EX forward selects, and the ID-stage WB bypass flags.

Parameters:
NREG, 8, architectural register count (power of 2, ≥2)
AW, $clog2(NREG), register-index width
NSRC, 2, source operands per instruction (1..3)
R0_ZERO, 1, 1 = register 0 is hard-wired zero (never a hazard, never forwarded)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
id_valid  in  1  valid instruction in ID
id_rs  in  NSRC*AW  packed source indices; src i = bits [i*AW +: AW]
id_src_used  in  NSRC  src i actually read
id_rd  in  AW  destination index
id_regwrite  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
flush  in  1  branch mispredict resolved in EX; kill instruction in ID
mem_stall  in  1  data memory busy; freeze whole back end
stall  out  1  hold PC and IF/ID
fwd_sel  out  2*NSRC  EX operand select per src: 00 ID/EX latch, 01 EX/MEM ALU result, 10 WB write data, 11 never driven
id_wb_byp  out  NSRC  src i in ID must take WB write data (no regfile write-through)
ex_rd, mem_rd, wb_rd  out  AW each  tracked destinations
wb_regwrite  out  1  valid & regwrite of WB slot
perf_stall_cnt  out  16  see Optional Feature
perf_fwd_cnt  out  16  see Optional Feature
perf_clr  in  1  see Optional Feature

Behaviour:
- Three slots (EX, MEM, WB). Each slot holds valid, rd, regwrite, is_load. The EX slot also holds rs[NSRC] and src_used.
- Reset: all slot fields 0, all slots invalid. stall, fwd_sel, id_wb_byp, wb_regwrite and perf counters are all 0.
- A source matches a slot when src_used=1, slot valid=1, regwrite=1, rd==rs, and not (R0_ZERO && rs==0).
- Load-use stall: stall = mem_stall | (id_valid & !flush & any ID src matches EX slot with is_load=1). stall is combinational from the registered slots and the current ID inputs.
- Edge update, in priority order:
  - mem_stall=1: all slots hold, including EX. flush is ignored; the upstream block holds flush until mem_stall drops.
  - Else if load-use stall or flush or !id_valid: EX slot gets a bubble (valid=0), MEM<=EX, WB<=MEM.
  - Else: EX<=ID fields, MEM<=EX, WB<=MEM.
- fwd_sel[i] (combinational, EX slot src i):
  - MEM slot match with is_load=0 gives 01.
  - Else WB slot match gives 10.
  - Else 00.
  - MEM has priority over WB when both match (youngest producer wins).
  - A MEM-slot load match gives 10 only if WB also matches, otherwise 00. This case is unreachable when the stall rule holds, and the bench asserts it never occurs.
- id_wb_byp[i] = id_valid & WB slot match on ID src i. It ignores stall.
- EX slot invalid: all fwd_sel = 00.
- Latency: load followed by a dependent instruction costs exactly 1 bubble. ALU followed by a dependent instruction costs 0 bubbles.
- Reset asserted mid-operation clears all slots immediately, without waiting for a clock edge.

Optional Feature:
Macro HAZ_PERF_EN.
- Defined:
  - perf_stall_cnt increments on each clk with stall=1.
  - perf_fwd_cnt increments on each clk where any fwd_sel≠00 and mem_stall=0.
  - Both counters are 16-bit, saturate at 16'hFFFF, and are cleared synchronously by perf_clr. Clear wins over increment.
- Not defined: counters are tied to 0, perf_clr is ignored, and no counter registers are inferred.

Test Plan:
- Back-to-back ALU: I1 rd=3, then I2 rs1=3 → stall=0. Next cycle, with I2 in EX, fwd_sel[1:0]=01.
- Load-use: LD rd=2, then ADD rs2=2 → stall=1 for exactly 1 cycle and the EX slot gets a bubble. With ADD in EX, fwd_sel[3:2]=10.
- Distance 2: I1 rd=5, filler, I3 rs1=5 → fwd_sel[1:0]=10. If the filler also writes rd=5, fwd_sel[1:0]=01 (MEM priority).
- R0: producer rd=0, consumer rs1=0 with R0_ZERO=1 → fwd_sel=00, no stall, and no id_wb_byp.
- Flush/mem_stall:
  - flush with a valid dependent instruction in ID → EX slot is a bubble next cycle and stall=0.
  - mem_stall=1 for 3 cycles → ex_rd/mem_rd/wb_rd are unchanged and stall=1 for all 3 cycles.
- HAZ_PERF_EN: 2 load-use stalls plus 3 forwards → perf_stall_cnt=2, perf_fwd_cnt=3. Pulsing perf_clr then gives 0/0.

Source files
------------

// File: rtl/hazard_fwd_scoreboard.sv
// Hazard/forwarding scoreboard for the 5-stage core: owns EX/MEM/WB destination tracking.
// Optional performance counters are built only when HAZ_PERF_EN is defined.
module hazard_fwd_scoreboard #(
    parameter int NREG    = 8,
    parameter int AW      = $clog2(NREG),
    parameter int NSRC    = 2,
    parameter int R0_ZERO = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_id_valid,
    input  logic [NSRC*AW-1:0]   i_id_rs,
    input  logic [NSRC-1:0]      i_id_src_used,
    input  logic [AW-1:0]        i_id_rd,
    input  logic                 i_id_regwrite,
    input  logic                 i_id_is_load,
    input  logic                 i_flush,
    input  logic                 i_mem_stall,
    input  logic                 i_perf_clr,
    output logic                 o_stall,
    output logic [2*NSRC-1:0]    o_fwd_sel,
    output logic [NSRC-1:0]      o_id_wb_byp,
    output logic [AW-1:0]        o_ex_rd,
    output logic [AW-1:0]        o_mem_rd,
    output logic [AW-1:0]        o_wb_rd,
    output logic                 o_wb_regwrite,
    output logic [15:0]          o_perf_stall_cnt,
    output logic [15:0]          o_perf_fwd_cnt
);

    logic                r_ex_valid, r_ex_regwrite, r_ex_is_load;
    logic [AW-1:0]       r_ex_rd;
    logic [NSRC*AW-1:0]  r_ex_rs;
    logic [NSRC-1:0]     r_ex_src_used;
    logic                r_mem_valid, r_mem_regwrite, r_mem_is_load;
    logic [AW-1:0]       r_mem_rd;
    logic                r_wb_valid, r_wb_regwrite, r_wb_is_load;
    logic [AW-1:0]       r_wb_rd;

    logic                w_load_hit;
    logic                w_lu_stall;
    logic [NSRC-1:0]     w_mem_hit;
    logic [NSRC-1:0]     w_wb_hit;

    function automatic logic f_match(input logic used, input logic valid, input logic regwrite,
                                     input logic [AW-1:0] rd, input logic [AW-1:0] rs);
        return used && valid && regwrite && (rd == rs) && !((R0_ZERO != 0) && (rs == '0));
    endfunction

    always_comb begin
        w_load_hit  = 1'b0;
        w_mem_hit   = '0;
        w_wb_hit    = '0;
        o_fwd_sel   = '0;
        o_id_wb_byp = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_load_hit = w_load_hit | f_match(i_id_src_used[i], r_ex_valid,
                                              r_ex_regwrite & r_ex_is_load,
                                              r_ex_rd, i_id_rs[i*AW +: AW]);
            w_mem_hit[i] = r_ex_valid & f_match(r_ex_src_used[i], r_mem_valid, r_mem_regwrite,
                                                r_mem_rd, r_ex_rs[i*AW +: AW]);
            w_wb_hit[i]  = r_ex_valid & f_match(r_ex_src_used[i], r_wb_valid, r_wb_regwrite,
                                                r_wb_rd, r_ex_rs[i*AW +: AW]);
            // A load in MEM has no data yet, so it never wins the EX/MEM path
            if (w_mem_hit[i] && !r_mem_is_load)
                o_fwd_sel[2*i +: 2] = 2'b01;
            else if (w_wb_hit[i])
                o_fwd_sel[2*i +: 2] = 2'b10;
            o_id_wb_byp[i] = i_id_valid & f_match(i_id_src_used[i], r_wb_valid, r_wb_regwrite,
                                                  r_wb_rd, i_id_rs[i*AW +: AW]);
        end
        w_lu_stall = i_id_valid & ~i_flush & w_load_hit;
        o_stall    = i_mem_stall | w_lu_stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_regwrite  <= 1'b0;
            r_ex_is_load   <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_rs        <= '0;
            r_ex_src_used  <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_is_load  <= 1'b0;
            r_mem_rd       <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_is_load   <= 1'b0;
            r_wb_rd        <= '0;
        end else if (!i_mem_stall) begin
            r_mem_valid    <= r_ex_valid;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_is_load  <= r_ex_is_load;
            r_mem_rd       <= r_ex_rd;
            r_wb_valid     <= r_mem_valid;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_is_load   <= r_mem_is_load;
            r_wb_rd        <= r_mem_rd;
            // Bubbles are fully zeroed so tracked rd outputs read 0 for empty slots
            if (w_lu_stall || i_flush || !i_id_valid) begin
                r_ex_valid    <= 1'b0;
                r_ex_regwrite <= 1'b0;
                r_ex_is_load  <= 1'b0;
                r_ex_rd       <= '0;
                r_ex_rs       <= '0;
                r_ex_src_used <= '0;
            end else begin
                r_ex_valid    <= 1'b1;
                r_ex_regwrite <= i_id_regwrite;
                r_ex_is_load  <= i_id_is_load;
                r_ex_rd       <= i_id_rd;
                r_ex_rs       <= i_id_rs;
                r_ex_src_used <= i_id_src_used;
            end
        end
    end

    assign o_ex_rd       = r_ex_rd;
    assign o_mem_rd      = r_mem_rd;
    assign o_wb_rd       = r_wb_rd;
    assign o_wb_regwrite = r_wb_valid & r_wb_regwrite;

`ifdef HAZ_PERF_EN
    logic [15:0] r_perf_stall_cnt;
    logic [15:0] r_perf_fwd_cnt;
    logic        w_unused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall_cnt <= '0;
            r_perf_fwd_cnt   <= '0;
        end else if (i_perf_clr) begin
            r_perf_stall_cnt <= '0;
            r_perf_fwd_cnt   <= '0;
        end else begin
            if (o_stall && (r_perf_stall_cnt != 16'hFFFF))
                r_perf_stall_cnt <= r_perf_stall_cnt + 16'd1;
            if ((|o_fwd_sel) && !i_mem_stall && (r_perf_fwd_cnt != 16'hFFFF))
                r_perf_fwd_cnt <= r_perf_fwd_cnt + 16'd1;
        end
    end

    assign o_perf_stall_cnt = r_perf_stall_cnt;
    assign o_perf_fwd_cnt   = r_perf_fwd_cnt;
    assign w_unused         = r_wb_is_load;
`else
    logic w_unused;

    assign o_perf_stall_cnt = '0;
    assign o_perf_fwd_cnt   = '0;
    assign w_unused         = r_wb_is_load ^ i_perf_clr;
`endif

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Directed bench for hazard_fwd_scoreboard (NREG=8, NSRC=2, R0_ZERO=1).
// Expected perf counts follow HAZ_PERF_EN as compiled.
module tb_hazard_fwd_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [5:0] id_rs;
    logic [1:0] id_src_used;
    logic [2:0] id_rd;
    logic       id_regwrite;
    logic       id_is_load;
    logic       flush;
    logic       mem_stall;
    logic       perf_clr;
    logic       stall;
    logic [3:0] fwd_sel;
    logic [1:0] id_wb_byp;
    logic [2:0] ex_rd, mem_rd, wb_rd;
    logic       wb_regwrite;
    logic [15:0] perf_stall_cnt, perf_fwd_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int n_viol  = 0;

`ifdef HAZ_PERF_EN
    localparam int EXP_STALLS = 2;
    localparam int EXP_FWDS   = 3;
`else
    localparam int EXP_STALLS = 0;
    localparam int EXP_FWDS   = 0;
`endif

    hazard_fwd_scoreboard #(.NREG(8), .NSRC(2), .R0_ZERO(1)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_id_valid       (id_valid),
        .i_id_rs          (id_rs),
        .i_id_src_used    (id_src_used),
        .i_id_rd          (id_rd),
        .i_id_regwrite    (id_regwrite),
        .i_id_is_load     (id_is_load),
        .i_flush          (flush),
        .i_mem_stall      (mem_stall),
        .i_perf_clr       (perf_clr),
        .o_stall          (stall),
        .o_fwd_sel        (fwd_sel),
        .o_id_wb_byp      (id_wb_byp),
        .o_ex_rd          (ex_rd),
        .o_mem_rd         (mem_rd),
        .o_wb_rd          (wb_rd),
        .o_wb_regwrite    (wb_regwrite),
        .o_perf_stall_cnt (perf_stall_cnt),
        .o_perf_fwd_cnt   (perf_fwd_cnt)
    );

    always #5 clk = ~clk;

    // An EX source matching a load still in MEM means the load-use stall was missed
    always @(negedge clk) begin
        if (!reset && dut.r_ex_valid && dut.r_mem_valid && dut.r_mem_regwrite && dut.r_mem_is_load) begin
            for (int i = 0; i < 2; i++) begin
                if (dut.r_ex_src_used[i] && (dut.r_ex_rs[i*3 +: 3] == dut.r_mem_rd) &&
                    (dut.r_mem_rd != 3'd0))
                    n_viol++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [1:0] used, input logic [2:0] rd,
                          input logic rw, input logic ld);
        id_valid    = v;
        id_rs       = {rs2, rs1};
        id_src_used = used;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_id(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic drain();
        repeat (3) idle();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        mem_stall = 1'b0;
        perf_clr  = 1'b0;
        set_id(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;

        check("rst_stall",  {31'd0, stall}, 0);
        check("rst_fwd",    {28'd0, fwd_sel}, 0);
        check("rst_byp",    {30'd0, id_wb_byp}, 0);
        check("rst_wbrw",   {31'd0, wb_regwrite}, 0);
        check("rst_rds",    {23'd0, ex_rd, mem_rd, wb_rd}, 0);
        check("rst_perf",   {perf_stall_cnt, perf_fwd_cnt}, 0);

        // back-to-back ALU dependency forwards from EX/MEM, no bubble
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd3, 3'd0, 2'b01, 3'd4, 1'b1, 1'b0);
        #1 check("alu_stall", {31'd0, stall}, 0);
        tick();
        check("alu_fwd",    {28'd0, fwd_sel}, 4'b0001);
        check("alu_ex_rd",  {29'd0, ex_rd}, 4);
        check("alu_mem_rd", {29'd0, mem_rd}, 3);
        idle();
        check("bubble_fwd", {28'd0, fwd_sel}, 0);
        check("alu_wb_rd",  {29'd0, wb_rd}, 3);
        check("alu_wb_rw",  {31'd0, wb_regwrite}, 1);
        set_id(1'b1, 3'd0, 3'd3, 2'b10, 3'd0, 1'b0, 1'b0);
        #1 check("wb_byp",  {30'd0, id_wb_byp}, 2'b10);
        drain();

        // load-use: one bubble, then WB forward on src 1
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd0, 3'd2, 2'b10, 3'd6, 1'b1, 1'b0);
        #1 check("lu_stall1", {31'd0, stall}, 1);
        tick();
        check("lu_bubble",  {29'd0, ex_rd}, 0);
        check("lu_stall2",  {31'd0, stall}, 0);
        tick();
        check("lu_fwd",     {28'd0, fwd_sel}, 4'b1000);
        check("lu_ex_rd",   {29'd0, ex_rd}, 6);
        drain();

        // distance 2 forwards from WB
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd5, 3'd0, 2'b01, 3'd1, 1'b1, 1'b0);
        tick();
        check("dist2_fwd", {28'd0, fwd_sel}, 4'b0010);
        drain();

        // distance 2 with filler also writing r5: MEM wins on both sources
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd5, 3'd5, 2'b11, 3'd1, 1'b1, 1'b0);
        tick();
        check("mem_prio_fwd", {28'd0, fwd_sel}, 4'b0101);
        drain();

        // R0 producer (a load) never stalls, forwards or bypasses
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd0, 3'd0, 2'b01, 3'd1, 1'b1, 1'b0);
        #1 check("r0_stall", {31'd0, stall}, 0);
        tick();
        check("r0_fwd", {28'd0, fwd_sel}, 0);
        set_id(1'b1, 3'd0, 3'd0, 2'b01, 3'd0, 1'b0, 1'b0);
        tick();
        check("r0_wb_rd", {29'd0, wb_rd}, 0);
        check("r0_byp", {30'd0, id_wb_byp}, 0);
        drain();

        // flush kills a dependent instruction in ID
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd4, 3'd0, 2'b01, 3'd6, 1'b1, 1'b0);
        flush = 1'b1;
        #1 check("flush_stall", {31'd0, stall}, 0);
        tick();
        flush = 1'b0;
        check("flush_ex_rd", {29'd0, ex_rd}, 0);
        check("flush_mem_rd", {29'd0, mem_rd}, 4);
        drain();

        // mem_stall freezes the whole back end for 3 cycles
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd2, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b0);
        mem_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check("ms_stall", {31'd0, stall}, 1);
            tick();
            check("ms_rds", {23'd0, ex_rd, mem_rd, wb_rd}, {23'd0, 3'd3, 3'd2, 3'd1});
        end
        mem_stall = 1'b0;
        drain();

        // perf: two load-use stalls and three forwards from a cleared start
        perf_clr = 1'b1;
        idle();
        perf_clr = 1'b0;
        check("perf_clr0", {perf_stall_cnt, perf_fwd_cnt}, 0);
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd0, 3'd2, 2'b10, 3'd6, 1'b1, 1'b0);
        tick();
        tick();
        idle();
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd3, 3'd0, 2'b01, 3'd6, 1'b1, 1'b0);
        tick();
        tick();
        check("perf_lu2_fwd", {28'd0, fwd_sel}, 4'b0010);
        idle();
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd5, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0);
        tick();
        idle();
        drain();
        check("perf_stall_cnt", {16'd0, perf_stall_cnt}, EXP_STALLS);
        check("perf_fwd_cnt",   {16'd0, perf_fwd_cnt}, EXP_FWDS);
        perf_clr = 1'b1;
        idle();
        perf_clr = 1'b0;
        check("perf_clr_cnts", {perf_stall_cnt, perf_fwd_cnt}, 0);

        // asynchronous reset clears slots between edges
        set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd6, 1'b1, 1'b0);
        tick();
        idle();
        idle();
        check("pre_rst_wbrw", {31'd0, wb_regwrite}, 1);
        #2 reset = 1'b1;
        #1 check("arst_wb_rd", {29'd0, wb_rd}, 0);
        check("arst_wbrw", {31'd0, wb_regwrite}, 0);
        #3 reset = 1'b0;
        tick();

        check("no_mem_load_match", n_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
